// File: rtl/uart_bridge_pkg.sv
// Shared constants and state encoding for the UART register bridge.
package uart_bridge_pkg;

   localparam logic [7:0] CMD_WR  = 8'h57;
   localparam logic [7:0] CMD_RD  = 8'h52;
   localparam logic [7:0] RSP_OK  = 8'h4B;
   localparam logic [7:0] RSP_ERR = 8'h45;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_DATA,
      ST_REG_WR,
      ST_REG_RD,
      ST_RD_WAIT,
      ST_SEND
   } state_e;

endpackage

// File: rtl/uart_reg_bridge.sv
// Command bridge: pops 'W'/'R' frames from the UART RX FIFO, runs an
// 8-bit register access and pushes one response byte to the TX FIFO.
module uart_reg_bridge
   import uart_bridge_pkg::*;
#(
   parameter int TIMEOUT = 2_500_000,
   parameter int TO_BIT  = 22
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx_empty,
   input  logic [7:0] r_data,
   output logic       rd_uart,
   input  logic       tx_full,
   output logic       wr_uart,
   output logic [7:0] w_data,
   output logic [7:0] reg_addr,
   output logic [7:0] reg_wdata,
   output logic       reg_wr,
   output logic       reg_rd,
   input  logic [7:0] reg_rdata,
   output logic       busy,
   output logic       err_tick
);

   localparam logic [TO_BIT-1:0] TO_LAST = TO_BIT'(TIMEOUT - 1);

   state_e            state_q;
   logic [7:0]        cmd_q;
   logic [7:0]        addr_q;
   logic [7:0]        wdata_q;
   logic [7:0]        rsp_q;
   logic              wr_q;
   logic              err_q;
   logic [TO_BIT-1:0] cnt_q;

   logic accept_st;
   logic pop;
   logic cnt_hit;
   logic is_cmd;

   assign accept_st = (state_q == ST_IDLE) ||
                      (state_q == ST_ADDR) ||
                      (state_q == ST_DATA);
   // Gated by reset so the pop strobe is also 0 while reset is held.
   assign pop     = accept_st & ~rx_empty & reset;
   assign cnt_hit = (cnt_q == TO_LAST);
   assign is_cmd  = (r_data == CMD_WR) || (r_data == CMD_RD);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cmd_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rsp_q   <= '0;
         wr_q    <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         err_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (pop) begin
                  cmd_q <= r_data;
                  cnt_q <= '0;
                  if (is_cmd) begin
                     state_q <= ST_ADDR;
                  end else begin
                     rsp_q   <= RSP_ERR;
                     err_q   <= 1'b1;
                     wr_q    <= ~tx_full;
                     state_q <= ST_SEND;
                  end
               end
            end
            ST_ADDR: begin
               if (pop) begin
                  addr_q  <= r_data;
                  cnt_q   <= '0;
                  state_q <= (cmd_q == CMD_WR) ? ST_DATA : ST_REG_RD;
               end else if (cnt_hit) begin
                  err_q   <= 1'b1;
                  cnt_q   <= '0;
                  state_q <= ST_IDLE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            ST_DATA: begin
               if (pop) begin
                  wdata_q <= r_data;
                  cnt_q   <= '0;
                  state_q <= ST_REG_WR;
               end else if (cnt_hit) begin
                  err_q   <= 1'b1;
                  cnt_q   <= '0;
                  state_q <= ST_IDLE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            ST_REG_WR: begin
               rsp_q   <= RSP_OK;
               wr_q    <= ~tx_full;
               state_q <= ST_SEND;
            end
            ST_REG_RD: begin
               state_q <= ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
               rsp_q   <= reg_rdata;
               wr_q    <= ~tx_full;
               state_q <= ST_SEND;
            end
            ST_SEND: begin
               // wr_q is the push strobe; it arms on a cycle with room.
               if (wr_q) begin
                  wr_q    <= 1'b0;
                  state_q <= ST_IDLE;
               end else begin
                  wr_q <= ~tx_full;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign rd_uart   = pop;
   assign wr_uart   = wr_q;
   assign w_data    = rsp_q;
   assign reg_addr  = addr_q;
   assign reg_wdata = wdata_q;
   assign reg_wr    = (state_q == ST_REG_WR);
   assign reg_rd    = (state_q == ST_REG_RD);
   assign busy      = (state_q != ST_IDLE);
   assign err_tick  = err_q;

endmodule

// File: tb/tb_uart_reg_bridge.sv
// Directed bench for uart_reg_bridge: FIFO and register-file models,
// a vector table for whole frames, and hand-written corner sequences.
module tb_uart_reg_bridge;

   logic       clk;
   logic       reset;
   logic       rx_empty;
   logic [7:0] r_data;
   logic       rd_uart;
   logic       tx_full;
   logic       wr_uart;
   logic [7:0] w_data;
   logic [7:0] reg_addr;
   logic [7:0] reg_wdata;
   logic       reg_wr;
   logic       reg_rd;
   logic [7:0] reg_rdata;
   logic       busy;
   logic       err_tick;

   uart_reg_bridge #(.TIMEOUT(16), .TO_BIT(5)) dut (
      .clk(clk), .reset(reset),
      .rx_empty(rx_empty), .r_data(r_data), .rd_uart(rd_uart),
      .tx_full(tx_full), .wr_uart(wr_uart), .w_data(w_data),
      .reg_addr(reg_addr), .reg_wdata(reg_wdata),
      .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_rdata(reg_rdata),
      .busy(busy), .err_tick(err_tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] b0, b1, b2;
      int         nb;
      int         exp_wr, exp_rd, exp_err;
      logic [7:0] exp_addr, exp_wd, exp_rsp;
   } vec_t;

   vec_t       tv[6];
   logic [7:0] q[$];
   logic [7:0] pushes[$];
   logic [7:0] mem[256];
   int n_vec, n_bad, cyc;
   int n_pop, n_wr, n_rd, n_push, n_err;
   int pop_cyc, wr_cyc, rd_cyc, push_cyc, err_cyc;
   logic [7:0] wr_addr, wr_data, rd_addr;
   logic last_busy, last_rd;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic refresh();
      rx_empty = (q.size() == 0);
      r_data   = (q.size() != 0) ? q[0] : 8'h00;
   endtask

   task automatic clear_stats();
      n_pop = 0; n_wr = 0; n_rd = 0; n_push = 0; n_err = 0;
      pop_cyc = -1; wr_cyc = -1; rd_cyc = -1;
      push_cyc = -1; err_cyc = -1;
      pushes.delete();
   endtask

   task automatic cycle();
      logic popped;
      @(negedge clk);
      popped    = rd_uart;
      last_busy = busy;
      last_rd   = rd_uart;
      if (rd_uart) begin n_pop++; pop_cyc = cyc; end
      if (reg_wr) begin
         n_wr++; wr_cyc = cyc;
         wr_addr = reg_addr; wr_data = reg_wdata;
         mem[reg_addr] = reg_wdata;
      end
      if (reg_rd) begin n_rd++; rd_cyc = cyc; rd_addr = reg_addr; end
      if (wr_uart) begin
         n_push++; push_cyc = cyc; pushes.push_back(w_data);
      end
      if (err_tick) begin n_err++; err_cyc = cyc; end
      @(posedge clk);
      #1;
      if (popped && q.size() != 0) void'(q.pop_front());
      refresh();
      reg_rdata = mem[reg_addr];
      cyc++;
   endtask

   task automatic feed(input logic [7:0] b);
      q.push_back(b);
      refresh();
   endtask

   task automatic run_idle(input string name, input int bound);
      int n;
      n = 0;
      do begin
         cycle();
         n++;
      end while (!(q.size() == 0 && !last_busy && !last_rd) && n < bound);
      if (n >= bound) check({name, " idle timeout"}, 32'd1, 32'd0);
      repeat (3) cycle();
   endtask

   task automatic check_outputs_zero(input string name);
      check({name, " rd_uart"}, 32'(rd_uart), 0);
      check({name, " wr_uart"}, 32'(wr_uart), 0);
      check({name, " w_data"}, 32'(w_data), 0);
      check({name, " reg_addr"}, 32'(reg_addr), 0);
      check({name, " reg_wdata"}, 32'(reg_wdata), 0);
      check({name, " reg_wr"}, 32'(reg_wr), 0);
      check({name, " reg_rd"}, 32'(reg_rd), 0);
      check({name, " busy"}, 32'(busy), 0);
      check({name, " err_tick"}, 32'(err_tick), 0);
   endtask

   initial begin
      int p;
      int drop;
      n_vec = 0; n_bad = 0; cyc = 0;
      last_busy = 0; last_rd = 0;
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      mem[8'h3C] = 8'h99;
      mem[8'h01] = 8'h5A;
      tv[0] = '{8'h57, 8'h10, 8'hA5, 3, 1, 0, 0, 8'h10, 8'hA5, 8'h4B};
      tv[1] = '{8'h52, 8'h3C, 8'h00, 2, 0, 1, 0, 8'h3C, 8'h00, 8'h99};
      tv[2] = '{8'h41, 8'h00, 8'h00, 1, 0, 0, 1, 8'h00, 8'h00, 8'h45};
      tv[3] = '{8'h52, 8'h01, 8'h00, 2, 0, 1, 0, 8'h01, 8'h00, 8'h5A};
      tv[4] = '{8'h57, 8'h3C, 8'h77, 3, 1, 0, 0, 8'h3C, 8'h77, 8'h4B};
      tv[5] = '{8'h52, 8'h3C, 8'h00, 2, 0, 1, 0, 8'h3C, 8'h00, 8'h77};
      clear_stats();

      reset = 1'b0; tx_full = 1'b0; reg_rdata = 8'h00;
      refresh();
      #23;
      check_outputs_zero("reset");
      rx_empty = 1'b0;
      #1;
      check("reset rd_uart gated", 32'(rd_uart), 0);
      refresh();
      @(posedge clk); #1;
      reset = 1'b1;

      for (int i = 0; i < 6; i++) begin
         string s;
         s = $sformatf("vec%0d", i);
         clear_stats();
         feed(tv[i].b0);
         if (tv[i].nb > 1) feed(tv[i].b1);
         if (tv[i].nb > 2) feed(tv[i].b2);
         run_idle(s, 60);
         check({s, " pops"}, 32'(n_pop), 32'(tv[i].nb));
         check({s, " reg_wr"}, 32'(n_wr), 32'(tv[i].exp_wr));
         check({s, " reg_rd"}, 32'(n_rd), 32'(tv[i].exp_rd));
         check({s, " err"}, 32'(n_err), 32'(tv[i].exp_err));
         check({s, " pushes"}, 32'(n_push), 1);
         if (n_push > 0) check({s, " rsp"}, 32'(pushes[0]), 32'(tv[i].exp_rsp));
         check({s, " busy"}, 32'(last_busy), 0);
         if (tv[i].exp_wr != 0) begin
            check({s, " addr"}, 32'(wr_addr), 32'(tv[i].exp_addr));
            check({s, " wdata"}, 32'(wr_data), 32'(tv[i].exp_wd));
            check({s, " wr lat"}, 32'(wr_cyc - pop_cyc), 1);
            check({s, " push lat"}, 32'(push_cyc - wr_cyc), 1);
         end
         if (tv[i].exp_rd != 0) begin
            check({s, " addr"}, 32'(rd_addr), 32'(tv[i].exp_addr));
            check({s, " rd lat"}, 32'(rd_cyc - pop_cyc), 1);
            check({s, " push lat"}, 32'(push_cyc - rd_cyc), 2);
         end
         if (tv[i].exp_err != 0) begin
            check({s, " err lat"}, 32'(err_cyc - pop_cyc), 1);
            check({s, " err vs push"}, 32'(err_cyc), 32'(push_cyc));
         end
      end

      // Timeout: a lone 'W' then silence.
      clear_stats();
      feed(8'h57);
      cycle();
      p = pop_cyc;
      check("to pop", 32'(n_pop), 1);
      repeat (30) cycle();
      check("to err", 32'(n_err), 1);
      check("to err cycle", 32'(err_cyc - p), 17);
      check("to push", 32'(n_push), 0);
      check("to reg_wr", 32'(n_wr), 0);
      check("to busy", 32'(last_busy), 0);
      clear_stats();
      feed(8'h57); feed(8'h20); feed(8'h01);
      run_idle("to wr", 60);
      check("to wr count", 32'(n_wr), 1);
      check("to wr addr", 32'(wr_addr), 32'h20);
      check("to wr data", 32'(wr_data), 32'h01);
      check("to wr rsp", 32'(n_push), 1);

      // Backpressure on a read response, with the next frame queued.
      clear_stats();
      tx_full = 1'b1;
      feed(8'h52); feed(8'h3C); feed(8'h52); feed(8'h01);
      repeat (50) cycle();
      check("bp pops", 32'(n_pop), 2);
      check("bp pushes", 32'(n_push), 0);
      check("bp busy", 32'(last_busy), 1);
      tx_full = 1'b0;
      drop = cyc;
      run_idle("bp", 60);
      check("bp push count", 32'(n_push), 2);
      check("bp push cycle", 32'(pushes.size() > 0 ? push_cyc : -1), 32'(push_cyc));
      if (pushes.size() == 2) begin
         check("bp rsp0", 32'(pushes[0]), 32'h77);
         check("bp rsp1", 32'(pushes[1]), 32'h5A);
      end
      check("bp rd count", 32'(n_rd), 2);
      check("bp pops total", 32'(n_pop), 4);

      // Recheck the drop-to-push distance with a fresh stalled read.
      clear_stats();
      tx_full = 1'b1;
      feed(8'h52); feed(8'h01);
      repeat (20) cycle();
      check("bp2 held", 32'(n_push), 0);
      tx_full = 1'b0;
      drop = cyc;
      run_idle("bp2", 20);
      check("bp2 push lat", 32'(push_cyc - drop), 1);
      check("bp2 rsp", 32'(pushes.size() > 0 ? pushes[0] : 8'hxx), 32'h5A);

      // Reset in the middle of a write frame.
      clear_stats();
      feed(8'h57); feed(8'h10);
      cycle(); cycle();
      check("rst pops", 32'(n_pop), 2);
      #2;
      reset = 1'b0;
      #1;
      check_outputs_zero("rst async");
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b1;
      clear_stats();
      feed(8'h52); feed(8'h10);
      run_idle("rst rd", 60);
      check("rst reg_wr", 32'(n_wr), 0);
      check("rst reg_rd", 32'(n_rd), 1);
      check("rst rd addr", 32'(rd_addr), 32'h10);
      check("rst push", 32'(n_push), 1);
      if (n_push > 0) check("rst rsp", 32'(pushes[0]), 32'hA5);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
